// File: rtl/pipe_ctrl.sv
// pipe_ctrl: run-control and hazard sequencer for a 5-stage RV32I pipeline
// Produces per-register load enables and bubble flushes for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB from RAW hazards, branch redirects and LSU busy holds,
// and adds debug halt/single-step sequencing and a busy watchdog.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   id_rs{1,2}_addr_i/_use_i         sources of the instruction in ID
//   {ex,mem,wb}_rd_addr_i/_wren_i    destinations of the instructions downstream
//   br_taken_i, mem_busy_i           redirect request, LSU not complete
//   halt_req_i, step_i               debug halt level, single-step pulse
//   *_en_o, *_flush_o                register load enables / bubble loads
//   state_o, halted_o, err_o         run state, halted flag, sticky watchdog error
//   stall_cnt_o, flush_cnt_o         performance counters
// Optional feature: define PIPE_CTRL_PERF_EN to build the performance counters;
// otherwise the counter ports read constant 0.
module pipe_ctrl #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_use_i,
  input  logic             id_rs2_use_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_i,
  input  logic [4:0]       mem_rd_addr_i,
  input  logic             mem_rd_wren_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic             wb_rd_wren_i,
  input  logic             br_taken_i,
  input  logic             mem_busy_i,
  input  logic             halt_req_i,
  input  logic             step_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             memwb_flush_o,
  output logic [1:0]       state_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, STEP = 2'd2} state_t;
  localparam logic [7:0] L_HOLD_MAX = 8'(HOLD_MAX);
  state_t     r_state, w_state_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic       r_err;
  logic       w_adv, w_rs1_hit, w_rs2_hit, w_raw;
  logic [8:0] w_ctl;
  // No regfile write-through, so a pending write in WB still counts as a hazard.
  assign w_rs1_hit = id_rs1_use_i && (id_rs1_addr_i != 5'd0) &&
                     ((ex_rd_wren_i  && ex_rd_addr_i  == id_rs1_addr_i) ||
                      (mem_rd_wren_i && mem_rd_addr_i == id_rs1_addr_i) ||
                      (wb_rd_wren_i  && wb_rd_addr_i  == id_rs1_addr_i));
  assign w_rs2_hit = id_rs2_use_i && (id_rs2_addr_i != 5'd0) &&
                     ((ex_rd_wren_i  && ex_rd_addr_i  == id_rs2_addr_i) ||
                      (mem_rd_wren_i && mem_rd_addr_i == id_rs2_addr_i) ||
                      (wb_rd_wren_i  && wb_rd_addr_i  == id_rs2_addr_i));
  assign w_raw = w_rs1_hit || w_rs2_hit;
  assign w_adv = (r_state == RUN || r_state == STEP) && !rst_i;
  // Control vector: {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}.
  // Busy hold drains a bubble into MEM/WB; a RAW stall freezes PC/IF-ID and bubbles ID/EX.
  always_comb begin
    w_ctl = !w_adv      ? 9'b00000_0000 :
            mem_busy_i  ? 9'b00000_0001 :
            br_taken_i  ? 9'b11111_1110 :
            w_raw       ? 9'b00111_0100 :
                          9'b11111_0000;
  end
  assign {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
          ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o} = w_ctl;
  // A step request wins over a halt drop so a single step is never lost.
  always_comb begin
    w_state_nxt = RUN;
    case (r_state)
      RUN:     w_state_nxt = halt_req_i ? HALT : RUN;
      HALT:    w_state_nxt = step_i ? STEP : (halt_req_i ? HALT : RUN);
      STEP:    w_state_nxt = halt_req_i ? HALT : RUN;
      default: w_state_nxt = RUN;
    endcase
  end
  // Hold counter freezes while not advancing and saturates so it cannot wrap back below the limit.
  always_comb begin
    w_hold_nxt = !w_adv      ? r_hold :
                 !mem_busy_i ? 8'd0 :
                 (&r_hold)   ? r_hold : r_hold + 8'd1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_hold  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_err   <= r_err || (w_hold_nxt >= L_HOLD_MAX);
    end
  end
  assign state_o  = r_state;
  assign halted_o = (r_state == HALT);
  assign err_o    = r_err;
`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] L_ONE = 1;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_stall_inc, w_flush_inc;
  assign w_stall_inc = w_adv && !pc_en_o && !(&r_stall_cnt);
  assign w_flush_inc = w_adv && !mem_busy_i && br_taken_i && !(&r_flush_cnt);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + L_ONE;
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + L_ONE;
    end
  end
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  localparam int HOLD_MAX = 15;
  localparam int CNT_W    = 32;
  localparam logic [8:0] ALL_EN = 9'b11111_0000;
  localparam logic [8:0] BR_FL  = 9'b11111_1110;
  localparam logic [8:0] BUSY   = 9'b00000_0001;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, mem_rd_addr_i, wb_rd_addr_i;
  logic id_rs1_use_i, id_rs2_use_i, ex_rd_wren_i, mem_rd_wren_i, wb_rd_wren_i;
  logic br_taken_i, mem_busy_i, halt_req_i, step_i;
  logic pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
  logic ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
  logic [1:0] state_o;
  logic halted_o, err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [8:0] obs_ctl;
  int total = 0;
  int bad = 0;
  int m_state, m_hold;
  bit m_err;
  longint m_stall, m_flush;
  pipe_ctrl #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wren_i(ex_rd_wren_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_wren_i(mem_rd_wren_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wren_i(wb_rd_wren_i),
    .br_taken_i(br_taken_i), .mem_busy_i(mem_busy_i),
    .halt_req_i(halt_req_i), .step_i(step_i),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .idex_en_o(idex_en_o),
    .exmem_en_o(exmem_en_o), .memwb_en_o(memwb_en_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .exmem_flush_o(exmem_flush_o), .memwb_flush_o(memwb_flush_o),
    .state_o(state_o), .halted_o(halted_o), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  assign obs_ctl = {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
                    ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask
  function automatic bit written(input logic [4:0] a);
    logic [4:0] rd [3];
    bit         we [3];
    rd = '{ex_rd_addr_i, mem_rd_addr_i, wb_rd_addr_i};
    we = '{ex_rd_wren_i, mem_rd_wren_i, wb_rd_wren_i};
    if (a == 5'd0) return 1'b0;
    foreach (rd[k]) if (we[k] && rd[k] == a) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit advancing();
    return (m_state != 1) && !rst_i;
  endfunction
  function automatic logic [8:0] exp_ctl();
    bit raw;
    raw = (id_rs1_use_i && written(id_rs1_addr_i)) || (id_rs2_use_i && written(id_rs2_addr_i));
    if (!advancing()) return 9'd0;
    if (mem_busy_i)   return BUSY;
    if (br_taken_i)   return BR_FL;
    if (raw)          return 9'b00111_0100;
    return ALL_EN;
  endfunction
  task automatic model_chk();
    @(negedge clk_i);
    chk("ctl", {55'd0, obs_ctl}, {55'd0, exp_ctl()});
    chk("state", {62'd0, state_o}, 64'(m_state));
    chk("halted", {63'd0, halted_o}, {63'd0, m_state == 1});
    chk("err", {63'd0, err_o}, {63'd0, m_err});
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cnt", 64'(stall_cnt_o), m_stall);
    chk("flush_cnt", 64'(flush_cnt_o), m_flush);
`else
    chk("stall_cnt", 64'(stall_cnt_o), 64'd0);
    chk("flush_cnt", 64'(flush_cnt_o), 64'd0);
`endif
  endtask
  task automatic model_step();
    logic [8:0] e;
    bit a;
    longint cmax;
    cmax = (longint'(1) << CNT_W) - 1;
    e = exp_ctl();
    a = advancing();
    if (rst_i) begin
      m_state = 0; m_hold = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (a) begin
        m_hold = mem_busy_i ? (m_hold < 255 ? m_hold + 1 : 255) : 0;
        if (m_hold >= HOLD_MAX) m_err = 1;
        if (!e[8] && m_stall < cmax) m_stall++;
        if (!mem_busy_i && br_taken_i && m_flush < cmax) m_flush++;
      end
      if (m_state == 0) m_state = halt_req_i ? 1 : 0;
      else if (m_state == 1) m_state = step_i ? 2 : (halt_req_i ? 1 : 0);
      else m_state = halt_req_i ? 1 : 0;
    end
    @(posedge clk_i);
    #1;
  endtask
  task automatic tick();
    model_chk();
    model_step();
  endtask
  task automatic clear_in();
    {id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, mem_rd_addr_i, wb_rd_addr_i} = '0;
    {id_rs1_use_i, id_rs2_use_i, ex_rd_wren_i, mem_rd_wren_i, wb_rd_wren_i} = '0;
    {br_taken_i, mem_busy_i, halt_req_i, step_i} = '0;
  endtask
  initial begin
    clear_in();
    rst_i = 1'b1;
    m_state = 0; m_hold = 0; m_err = 0; m_stall = 0; m_flush = 0;
    @(posedge clk_i);
    #1;
    tick();
    model_chk(); chk("rst_ctl_zero", {55'd0, obs_ctl}, 64'd0); model_step();
    rst_i = 1'b0;
    tick();
    // RAW writer shifting EX -> MEM -> WB, then gone
    id_rs1_addr_i = 5'd5; id_rs1_use_i = 1'b1;
    ex_rd_addr_i = 5'd5; ex_rd_wren_i = 1'b1;
    model_chk(); chk("raw_ex", {55'd0, obs_ctl}, {55'd0, 9'b00111_0100}); model_step();
    ex_rd_wren_i = 1'b0; mem_rd_addr_i = 5'd5; mem_rd_wren_i = 1'b1;
    model_chk(); chk("raw_mem", {55'd0, obs_ctl}, {55'd0, 9'b00111_0100}); model_step();
    mem_rd_wren_i = 1'b0; wb_rd_addr_i = 5'd5; wb_rd_wren_i = 1'b1;
    model_chk(); chk("raw_wb", {55'd0, obs_ctl}, {55'd0, 9'b00111_0100}); model_step();
    wb_rd_wren_i = 1'b0;
    model_chk(); chk("raw_done", {55'd0, obs_ctl}, {55'd0, ALL_EN}); model_step();
    // rs2 hazard with rs1 clean
    clear_in();
    id_rs2_addr_i = 5'd9; id_rs2_use_i = 1'b1; mem_rd_addr_i = 5'd9; mem_rd_wren_i = 1'b1;
    model_chk(); chk("raw_rs2", {55'd0, obs_ctl}, {55'd0, 9'b00111_0100}); model_step();
    // x0 never a hazard
    clear_in();
    id_rs1_use_i = 1'b1; ex_rd_wren_i = 1'b1;
    model_chk(); chk("x0_no_haz", {55'd0, obs_ctl}, {55'd0, ALL_EN}); model_step();
    // branch beats RAW
    id_rs1_addr_i = 5'd7; ex_rd_addr_i = 5'd7; br_taken_i = 1'b1;
    model_chk(); chk("br_beats_raw", {55'd0, obs_ctl}, {55'd0, BR_FL}); model_step();
    // busy beats branch for 3 cycles, then branch flush applies
    clear_in();
    br_taken_i = 1'b1; mem_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      model_chk(); chk("busy_beats_br", {55'd0, obs_ctl}, {55'd0, BUSY}); model_step();
    end
    mem_busy_i = 1'b0;
    model_chk(); chk("br_after_busy", {55'd0, obs_ctl}, {55'd0, BR_FL}); model_step();
    br_taken_i = 1'b0;
    // halt and single step
    halt_req_i = 1'b1;
    model_chk(); chk("halt_cycle_adv", {55'd0, obs_ctl}, {55'd0, ALL_EN}); model_step();
    for (int i = 0; i < 3; i++) begin
      model_chk(); chk("halted_frozen", {55'd0, obs_ctl}, 64'd0); model_step();
    end
    step_i = 1'b1;
    model_chk(); chk("halt_state", {62'd0, state_o}, 64'd1); model_step();
    step_i = 1'b0;
    model_chk(); chk("step_state", {62'd0, state_o}, 64'd2);
    chk("step_en", {55'd0, obs_ctl}, {55'd0, ALL_EN}); model_step();
    model_chk(); chk("rehalt_state", {62'd0, state_o}, 64'd1); model_step();
    tick(); tick();
    halt_req_i = 1'b0;
    tick();
    model_chk(); chk("resume_state", {62'd0, state_o}, 64'd0); model_step();
    // watchdog: HOLD_MAX busy advancing cycles, sticky until reset
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    mem_busy_i = 1'b1;
    for (int i = 0; i < HOLD_MAX; i++) tick();
    mem_busy_i = 1'b0;
    model_chk(); chk("wd_err_set", {63'd0, err_o}, 64'd1);
`ifdef PIPE_CTRL_PERF_EN
    chk("wd_stall15", 64'(stall_cnt_o), 64'(HOLD_MAX));
`endif
    model_step();
    for (int i = 0; i < 3; i++) tick();
    model_chk(); chk("wd_sticky", {63'd0, err_o}, 64'd1); model_step();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    model_chk(); chk("wd_cleared", {63'd0, err_o}, 64'd0); model_step();
    // watchdog one short of limit, and a halt mid-hold keeps the count
    mem_busy_i = 1'b1;
    for (int i = 0; i < HOLD_MAX - 1; i++) tick();
    model_chk(); chk("wd_below", {63'd0, err_o}, 64'd0);
    halt_req_i = 1'b1; model_step();
    tick(); tick();
    halt_req_i = 1'b0;
    tick();
    tick();
    model_chk(); chk("wd_after_halt", {63'd0, err_o}, 64'd1); model_step();
    // randomized phase
    clear_in();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      id_rs1_addr_i = 5'($urandom_range(0, 3));
      id_rs2_addr_i = 5'($urandom_range(0, 3));
      ex_rd_addr_i  = 5'($urandom_range(0, 3));
      mem_rd_addr_i = 5'($urandom_range(0, 3));
      wb_rd_addr_i  = 5'($urandom_range(0, 3));
      id_rs1_use_i  = 1'($urandom_range(0, 1));
      id_rs2_use_i  = 1'($urandom_range(0, 1));
      ex_rd_wren_i  = ($urandom_range(0, 2) == 0);
      mem_rd_wren_i = ($urandom_range(0, 2) == 0);
      wb_rd_wren_i  = ($urandom_range(0, 2) == 0);
      br_taken_i    = ($urandom_range(0, 6) == 0);
      mem_busy_i    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) halt_req_i = ~halt_req_i;
      step_i        = ($urandom_range(0, 5) == 0);
      rst_i         = ($urandom_range(0, 99) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
